mul_operand_streamer: RTL and testbench
=======================================

# mul_operand_streamer

Operand source for `matrix_multiplication` in the matrix-inversion datapath. It holds one 3x3 R-inverse matrix (A) and one Q-transpose matrix (B) in local register banks, loaded by a write port. On `start` it streams the 9 element pairs onto `r_mat_inv`/`transpose_out` with single-cycle `valid_mul` pulses. It then waits for the multiplier's `done_mul` and reports completion.

## Interface
- `WORDLEN`, 16: element width, signed fixed point; the block passes elements through unchanged.
- `MATRIX_DIM`, 3: matrix side length.
- `MATRIX_ELEMENT_NUM`, 9: element count; must equal `MATRIX_DIM`².
- `GAP_CYCLES`, 1: idle cycles with `valid_mul` low between consecutive pulses; range 0..15.

Ports:
- `CLK`, in, 1: clock; all logic is on the rising edge.
- `RST_n`, in, 1: reset; asynchronous assert, active-low.
- `wr_en`, in, 1: writes `wr_data` to bank `wr_sel` at `wr_addr`.
- `wr_sel`, in, 1: bank select; 0 = A, 1 = B.
- `wr_addr`, in, $clog2(MATRIX_ELEMENT_NUM): row-major element index.
- `wr_data`, in, WORDLEN: element value.
- `start`, in, 1: one-cycle request to stream the banks.
- `done_mul`, in, 1: completion pulse from the multiplier.
- `r_mat_inv`, out, WORDLEN: A operand.
- `transpose_out`, out, WORDLEN: B operand.
- `valid_mul`, out, 1: operand pair valid.
- `busy`, out, 1: high from the cycle after `start` is accepted until the cycle of `stream_done`.
- `stream_done`, out, 1: one-cycle pulse when the multiplier has finished.
- `err`, out, 1: one-cycle pulse when a request is rejected.

## Operation
- The FSM has four states: IDLE, EMIT, GAP and WAIT_DONE.
- **IDLE:** `start`=1 loads idx=0 and moves to EMIT.
- **EMIT:** drives the pair at idx with `valid_mul`=1 for exactly one cycle.
  - If idx=8, go to WAIT_DONE.
  - Else if `GAP_CYCLES`=0, idx++ and stay in EMIT.
  - Else go to GAP.
- **GAP:** `valid_mul`=0 for `GAP_CYCLES` cycles, then idx++ and go to EMIT.
- **WAIT_DONE:** on `done_mul`=1, pulse `stream_done` for one cycle and go to IDLE.
- `done_mul` seen in EMIT or GAP is ignored and is not latched.
- **Operand ordering:** pair n is `r_mat_inv`=A[n]. `transpose_out` is B[n], or the transposed read described under Configuration.
- **Operand hold:** both operand outputs keep the last emitted value while `valid_mul`=0. They are registered, with no combinational path from the banks.
- **Writes:** accepted only while `busy`=0; banks and outputs are unaffected by rejected writes.
- **Rejected requests:** each of the following pulses `err` for one cycle and is otherwise ignored:
  - `wr_en` while `busy`=1;
  - `wr_addr` ≥ `MATRIX_ELEMENT_NUM`;
  - `start` while `busy`=1.
- **Simultaneous `wr_en` and `start` in IDLE:** the write lands before streaming, so pair 0 sees the new data.
- **Reset values:** all outputs are 0, both banks are 0, idx=0, state=IDLE.
- **Reset mid-stream:** `valid_mul` drops immediately and asynchronously. Nothing resumes after reset; a new `start` is required.

## Timing
- `start` is sampled at edge T0. The first `valid_mul` is high during cycle T0+1.
- Pulse k (0..8) is at T0+1+k·(GAP_CYCLES+1).
- With `GAP_CYCLES`=1, pulses fall at T0+1, 3, …, 17 and WAIT_DONE begins at T0+18.
- `stream_done` is high in the cycle after `done_mul` is sampled. `busy` falls in that same cycle.
- A new `start` is accepted in that same cycle; it is not a `start` while busy.
- `err` is high in the cycle after the offending input is sampled.

## Configuration
- `MUL_OPERAND_TRANSPOSE_EN` defined: `transpose_out` for pair n is B[(n % MATRIX_DIM)·MATRIX_DIM + n / MATRIX_DIM]. B is therefore loaded as Q and transposed on the fly.
- `MUL_OPERAND_TRANSPOSE_EN` undefined: `transpose_out` is B[n]. The host loads an already-transposed matrix.

## Test plan
- **Load and stream:** load A={0333,04cd,0666,0000,019a,0800,0000,0000,0ccd} and B={01ec,feb8,f4cd,01a4,ff5c,f733,0444,01aa,0829}, macro undefined, `GAP_CYCLES`=1. Pulse `start`.
  - Required: 9 pulses at T0+1,3,…,17 carrying the pairs in index order.
  - Required: `busy` stays 1 until `done_mul`; drive `done_mul` at T0+25 and `stream_done` pulses at T0+26.
- **Transpose:** same data with the macro defined.
  - Required: pair 1 is (04cd,01a4), pair 3 is (0000,feb8), pair 8 is (0ccd,0829).
- **Back-to-back:** `GAP_CYCLES`=0.
  - Required: `valid_mul` is high for 9 consecutive cycles, T0+1..T0+9.
- **Error cases:**
  - `start` and `wr_en` at T0+4 → `err`=1 at T0+5, stream unchanged, banks unchanged.
  - `wr_addr`=9 in IDLE → `err` pulse, no bank change.
- **Early done and mid-stream reset:** `done_mul` at T0+6 is ignored and the block is still in WAIT_DONE after pulse 8. `RST_n`=0 at T0+8 → all outputs 0 at once, a re-read of the banks gives 0, and a fresh `start` streams zeros.

Source files
------------

// File: rtl/mul_operand_streamer.sv
// Operand streamer for matrix_multiplication: holds A (R-inverse) and B (Q-transpose) banks and
// emits the 9 element pairs on start. Optional macro MUL_OPERAND_TRANSPOSE_EN reads B column-major.
module mul_operand_streamer #(
    parameter int WORDLEN            = 16,
    parameter int MATRIX_DIM         = 3,
    parameter int MATRIX_ELEMENT_NUM = 9,
    parameter int GAP_CYCLES         = 1
) (
    input  logic                                  CLK,
    input  logic                                  RST_n,
    input  logic                                  wr_en,
    input  logic                                  wr_sel,
    input  logic [$clog2(MATRIX_ELEMENT_NUM)-1:0] wr_addr,
    input  logic [WORDLEN-1:0]                    wr_data,
    input  logic                                  start,
    input  logic                                  done_mul,
    output logic [WORDLEN-1:0]                    r_mat_inv,
    output logic [WORDLEN-1:0]                    transpose_out,
    output logic                                  valid_mul,
    output logic                                  busy,
    output logic                                  stream_done,
    output logic                                  err
);
    localparam int AW = $clog2(MATRIX_ELEMENT_NUM);
    localparam int GW = 4;
    localparam logic [AW-1:0] LAST = AW'(MATRIX_ELEMENT_NUM - 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP, WAIT_DONE} state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [GW-1:0]     gap_cnt;
    logic [WORDLEN-1:0] bank_a [MATRIX_ELEMENT_NUM];
    logic [WORDLEN-1:0] bank_b [MATRIX_ELEMENT_NUM];

    logic              addr_bad, wr_ok, req_bad;
    logic [AW-1:0]     rd_idx, rd_b_idx;
    logic [WORDLEN-1:0] rd_a, rd_b;

    function automatic logic [AW-1:0] b_addr(input logic [AW-1:0] n);
`ifdef MUL_OPERAND_TRANSPOSE_EN
        b_addr = AW'((int'(n) % MATRIX_DIM) * MATRIX_DIM + int'(n) / MATRIX_DIM);
`else
        b_addr = n;
`endif
    endfunction

    always_comb begin
        addr_bad = int'(wr_addr) >= MATRIX_ELEMENT_NUM;
        wr_ok    = wr_en && !busy && !addr_bad;
        req_bad  = (wr_en && (busy || addr_bad)) || (start && busy);
        // Index of the next pair to register; clamped so the bank read never leaves range.
        rd_idx   = (state == IDLE || idx == LAST) ? '0 : idx + 1'b1;
        rd_b_idx = b_addr(rd_idx);
        // A write landing on the same edge as start must be visible in pair 0.
        rd_a = (wr_ok && !wr_sel && wr_addr == rd_idx)   ? wr_data : bank_a[rd_idx];
        rd_b = (wr_ok &&  wr_sel && wr_addr == rd_b_idx) ? wr_data : bank_b[rd_b_idx];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state         <= IDLE;
            idx           <= '0;
            gap_cnt       <= '0;
            r_mat_inv     <= '0;
            transpose_out <= '0;
            valid_mul     <= 1'b0;
            busy          <= 1'b0;
            stream_done   <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < MATRIX_ELEMENT_NUM; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else begin
            valid_mul   <= 1'b0;
            stream_done <= 1'b0;
            err         <= req_bad;
            if (wr_ok) begin
                if (wr_sel) bank_b[wr_addr] <= wr_data;
                else        bank_a[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        state         <= EMIT;
                        busy          <= 1'b1;
                        valid_mul     <= 1'b1;
                        r_mat_inv     <= rd_a;
                        transpose_out <= rd_b;
                    end
                end
                EMIT: begin
                    if (idx == LAST) begin
                        state <= WAIT_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        idx           <= idx + 1'b1;
                        valid_mul     <= 1'b1;
                        r_mat_inv     <= rd_a;
                        transpose_out <= rd_b;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        idx           <= idx + 1'b1;
                        state         <= EMIT;
                        valid_mul     <= 1'b1;
                        r_mat_inv     <= rd_a;
                        transpose_out <= rd_b;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done_mul) begin
                        stream_done <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_operand_streamer.sv
// Directed bench for mul_operand_streamer: one GAP_CYCLES=1 instance and one back-to-back instance.
module tb_mul_operand_streamer;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        wr_en, wr_en0, wr_sel;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start, start0, done_mul, done0;
    logic [15:0] r, t, r0, t0;
    logic        v, bsy, sd, err, v0, bsy0, sd0, err0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] A [9] = '{16'h0333, 16'h04cd, 16'h0666, 16'h0000, 16'h019a,
                           16'h0800, 16'h0000, 16'h0000, 16'h0ccd};
    logic [15:0] B [9] = '{16'h01ec, 16'hfeb8, 16'hf4cd, 16'h01a4, 16'hff5c,
                           16'hf733, 16'h0444, 16'h01aa, 16'h0829};

    always #5 CLK = ~CLK;

    mul_operand_streamer #(.GAP_CYCLES(1)) dut (
        .CLK(CLK), .RST_n(RST_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .done_mul(done_mul), .r_mat_inv(r),
        .transpose_out(t), .valid_mul(v), .busy(bsy), .stream_done(sd), .err(err));

    mul_operand_streamer #(.GAP_CYCLES(0)) dut0 (
        .CLK(CLK), .RST_n(RST_n), .wr_en(wr_en0), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start0), .done_mul(done0), .r_mat_inv(r0),
        .transpose_out(t0), .valid_mul(v0), .busy(bsy0), .stream_done(sd0), .err(err0));

    // Expected B index for pair n
    function automatic int bx(input int n);
`ifdef MUL_OPERAND_TRANSPOSE_EN
        return (n % 3) * 3 + n / 3;
`else
        return n;
`endif
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({r, t, v, bsy, sd, err} !== 36'd0) begin
            n_fail++; $display("FAIL reset_dut got %h want 0", {r, t, v, bsy, sd, err});
        end
        n_checks++;
        if ({r0, t0, v0, bsy0, sd0, err0} !== 36'd0) begin
            n_fail++; $display("FAIL reset_dut0 got %h want 0", {r0, t0, v0, bsy0, sd0, err0});
        end
        RST_n = 1'b1;
    endtask

    task automatic load_banks();
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            wr_en = 1'b1; wr_en0 = 1'b1;
            wr_sel = (i >= 9);
            wr_addr = 4'(i % 9);
            wr_data = (i >= 9) ? B[i-9] : A[i];
        end
        @(negedge CLK);
        wr_en = 1'b0; wr_en0 = 1'b0;
    endtask

    task automatic test_load_stream();
        logic        ev;
        logic [15:0] t1, t3, t8;
`ifdef MUL_OPERAND_TRANSPOSE_EN
        t1 = 16'h01a4; t3 = 16'hfeb8; t8 = 16'h0829;
`else
        t1 = 16'hfeb8; t3 = 16'h01a4; t8 = 16'h0829;
`endif
        load_banks();
        @(negedge CLK); start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(negedge CLK);
            start = 1'b0;
            ev = (k % 2 == 1) && (k <= 17);
            n_checks++;
            if (v !== ev) begin n_fail++; $display("FAIL stream_valid k=%0d got %b want %b", k, v, ev); end
            if (ev) begin
                n_checks++;
                if (r !== A[(k-1)/2]) begin n_fail++; $display("FAIL stream_a k=%0d got %h want %h", k, r, A[(k-1)/2]); end
                n_checks++;
                if (t !== B[bx((k-1)/2)]) begin n_fail++; $display("FAIL stream_b k=%0d got %h want %h", k, t, B[bx((k-1)/2)]); end
            end else if (k <= 18) begin
                n_checks++;
                if (r !== A[(k-2)/2]) begin n_fail++; $display("FAIL hold_a k=%0d got %h want %h", k, r, A[(k-2)/2]); end
            end
            if (k == 3 || k == 7 || k == 17) begin
                n_checks++;
                if (t !== (k == 3 ? t1 : k == 7 ? t3 : t8)) begin
                    n_fail++; $display("FAIL transpose_pair k=%0d got %h want %h", k, t, (k == 3 ? t1 : k == 7 ? t3 : t8));
                end
            end
            n_checks++;
            if (bsy !== (k <= 25)) begin n_fail++; $display("FAIL stream_busy k=%0d got %b want %b", k, bsy, (k <= 25)); end
            n_checks++;
            if (sd !== (k == 26)) begin n_fail++; $display("FAIL stream_done k=%0d got %b want %b", k, sd, (k == 26)); end
            n_checks++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL stream_err k=%0d got %b want 0", k, err); end
            // done_mul at T0+6 arrives mid-stream and must be ignored
            done_mul = (k == 6) || (k == 25);
        end
    endtask

    task automatic test_errors();
        logic ev;
        @(negedge CLK);
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd9; wr_data = 16'hffff;
        @(negedge CLK);
        wr_en = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL addr9_err got %b want 1", err); end
        @(negedge CLK);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL addr9_err_clear got %b want 0", err); end
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            ev = (k % 2 == 1) && (k <= 17);
            n_checks++;
            if (err !== (k == 5)) begin n_fail++; $display("FAIL busy_err k=%0d got %b want %b", k, err, (k == 5)); end
            n_checks++;
            if (v !== ev) begin n_fail++; $display("FAIL err_valid k=%0d got %b want %b", k, v, ev); end
            if (ev) begin
                n_checks++;
                if (r !== A[(k-1)/2]) begin n_fail++; $display("FAIL err_a k=%0d got %h want %h", k, r, A[(k-1)/2]); end
                n_checks++;
                if (t !== B[bx((k-1)/2)]) begin n_fail++; $display("FAIL err_b k=%0d got %h want %h", k, t, B[bx((k-1)/2)]); end
            end
            start = (k == 4);
            wr_en = (k == 4);
            wr_sel = 1'b0; wr_addr = 4'd4; wr_data = 16'h7777;
            done_mul = (k == 20);
        end
        @(negedge CLK);
        done_mul = 1'b0;
        n_checks++;
        if (sd !== 1'b1 || bsy !== 1'b0) begin n_fail++; $display("FAIL err_finish got sd=%b busy=%b want 1 0", sd, bsy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea;
        @(negedge CLK);
        start0 = 1'b1; wr_en0 = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'h1234;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            start0 = 1'b0; wr_en0 = 1'b0;
            n_checks++;
            if (v0 !== (k <= 9)) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b want %b", k, v0, (k <= 9)); end
            if (k <= 10) begin
                ea = (k == 1) ? 16'h1234 : A[(k <= 9 ? k : 9) - 1];
                n_checks++;
                if (r0 !== ea) begin n_fail++; $display("FAIL b2b_a k=%0d got %h want %h", k, r0, ea); end
                n_checks++;
                if (t0 !== B[bx((k <= 9 ? k : 9) - 1)]) begin
                    n_fail++; $display("FAIL b2b_b k=%0d got %h want %h", k, t0, B[bx((k <= 9 ? k : 9) - 1)]);
                end
            end
            n_checks++;
            if (bsy0 !== (k <= 11)) begin n_fail++; $display("FAIL b2b_busy k=%0d got %b want %b", k, bsy0, (k <= 11)); end
            n_checks++;
            if (sd0 !== (k == 12)) begin n_fail++; $display("FAIL b2b_done k=%0d got %b want %b", k, sd0, (k == 12)); end
            done0 = (k == 11);
        end
    endtask

    task automatic test_mid_reset();
        logic ev;
        @(negedge CLK); start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        n_checks++;
        if (bsy !== 1'b1 || t === 16'h0000) begin n_fail++; $display("FAIL pre_reset got busy=%b t=%h want busy 1 t nonzero", bsy, t); end
        RST_n = 1'b0;
        #1;
        n_checks++;
        if ({r, t, v, bsy, sd, err} !== 36'd0) begin
            n_fail++; $display("FAIL async_reset got %h want 0", {r, t, v, bsy, sd, err});
        end
        @(negedge CLK); RST_n = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (bsy !== 1'b0 || v !== 1'b0) begin n_fail++; $display("FAIL no_resume got busy=%b v=%b want 0 0", bsy, v); end
        start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            start = 1'b0;
            ev = (k % 2 == 1) && (k <= 17);
            n_checks++;
            if (v !== ev) begin n_fail++; $display("FAIL zero_valid k=%0d got %b want %b", k, v, ev); end
            n_checks++;
            if (r !== 16'h0 || t !== 16'h0) begin n_fail++; $display("FAIL zero_data k=%0d got %h %h want 0 0", k, r, t); end
            done_mul = (k == 19);
        end
        @(negedge CLK);
        done_mul = 1'b0;
        n_checks++;
        if (sd !== 1'b1) begin n_fail++; $display("FAIL zero_finish got %b want 1", sd); end
    endtask

    initial begin
        RST_n = 1'b0;
        wr_en = 1'b0; wr_en0 = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        start = 1'b0; start0 = 1'b0; done_mul = 1'b0; done0 = 1'b0;
        test_reset();
        test_load_stream();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
